intel_fpga_pb_event_detect: RTL and testbench

- Per-button event stage that sits directly downstream of the pushbutton debounce channel. It consumes the debounced level and the shared sample_en tick.
- Classifies activity into press, release, long-press and auto-repeat events. Each event is a one-cycle pulse and also sets a sticky status bit.
- The status bits are masked into a single level interrupt, which feeds the board-control CSR/IRQ fabric.

---
 rtl/intel_fpga_pb_pkg.sv | 16 +
 rtl/intel_fpga_pb_status_reg.sv | 36 +++
 rtl/intel_fpga_pb_event_detect.sv | 125 ++++++++++++
 tb/tb_intel_fpga_pb_event_detect.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intel_fpga_pb_pkg.sv
// Shared types for the pushbutton event path.
//   pb_state_t  : event FSM states
//   pb_status_t : sticky status vector {repeat, long, release, press}
//   ST_*        : bit positions inside pb_status_t
package intel_fpga_pb_pkg;

  typedef enum logic [1:0] {INIT, IDLE, PRESSED, LONG} pb_state_t;

  localparam int ST_PRESS   = 0;
  localparam int ST_RELEASE = 1;
  localparam int ST_LONG    = 2;
  localparam int ST_REPEAT  = 3;

  typedef logic [3:0] pb_status_t;

endpackage

// File: rtl/intel_fpga_pb_status_reg.sv
// Sticky write-one-to-clear status register with masked level interrupt.
//   clk, rst   : clock, async active-high reset
//   i_set      : one-cycle event strobes, one per status bit
//   i_clr      : W1C strobes, honoured every cycle
//   i_mask     : interrupt enable per status bit
//   o_status   : sticky status bits
//   o_irq      : registered OR of (status & mask)
module intel_fpga_pb_status_reg
  import intel_fpga_pb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  pb_status_t i_set,
  input  pb_status_t i_clr,
  input  pb_status_t i_mask,
  output pb_status_t o_status,
  output logic       o_irq
);

  pb_status_t status_nxt;

  // Set wins over a coincident clear.
  assign status_nxt = (o_status & ~i_clr) | i_set;

  // irq is built from the next status so it rises together with the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_status <= '0;
      o_irq    <= 1'b0;
    end else begin
      o_status <= status_nxt;
      o_irq    <= |(status_nxt & i_mask);
    end
  end

endmodule

// File: rtl/intel_fpga_pb_event_detect.sv
// Per-button event classifier behind the debounce channel.
//   clk, rst     : clock, async active-high reset
//   sample_en    : sample tick shared with the debouncer; FSM advances only here
//   i_pb         : debounced level (polarity set by ACTIVE_LOW)
//   i_irq_mask   : irq enable {repeat, long, release, press}
//   i_clr        : W1C for status bits
//   o_press/o_release/o_long/o_repeat : one-clk event pulses
//   o_held       : 1 while PRESSED or LONG
//   o_status     : sticky event bits, o_irq : masked level interrupt
module intel_fpga_pb_event_detect
  import intel_fpga_pb_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int CNT_W        = 16,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       i_pb,
  input  logic [3:0] i_irq_mask,
  input  logic [3:0] i_clr,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic       o_repeat,
  output logic       o_held,
  output logic [3:0] o_status,
  output logic       o_irq
);

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_TICKS);
  localparam logic             POL    = (ACTIVE_LOW != 0);

  pb_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  pb_status_t       ev;
  logic             pressed;

  assign pressed = i_pb ^ POL;
  assign cnt_inc = cnt + CNT_W'(1);

  // Next-state/event decode. Events are needed combinationally so the
  // status register can set in the same cycle the pulse registers.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ev        = '0;
    if (sample_en) begin
      unique case (state)
        // First sample only latches the level: the debouncer resets to 0,
        // which would otherwise look like a press on active-low buttons.
        INIT: begin
          state_nxt = pressed ? PRESSED : IDLE;
          cnt_nxt   = '0;
        end
        IDLE: begin
          if (pressed) begin
            state_nxt    = PRESSED;
            cnt_nxt      = '0;
            ev[ST_PRESS] = 1'b1;
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state_nxt      = IDLE;
            ev[ST_RELEASE] = 1'b1;
          end else if (cnt_inc == LONG_C) begin
            state_nxt   = LONG;
            cnt_nxt     = '0;
            ev[ST_LONG] = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        LONG: begin
          // Release takes priority over a repeat due on the same sample.
          if (!pressed) begin
            state_nxt      = IDLE;
            ev[ST_RELEASE] = 1'b1;
          end else if (cnt_inc == REP_C) begin
            cnt_nxt       = '0;
            ev[ST_REPEAT] = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
      o_held    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      o_press   <= ev[ST_PRESS];
      o_release <= ev[ST_RELEASE];
      o_long    <= ev[ST_LONG];
      o_repeat  <= ev[ST_REPEAT];
      o_held    <= (state_nxt == PRESSED) || (state_nxt == LONG);
    end
  end

  intel_fpga_pb_status_reg u_status (
    .clk      (clk),
    .rst      (rst),
    .i_set    (ev),
    .i_clr    (i_clr),
    .i_mask   (i_irq_mask),
    .o_status (o_status),
    .o_irq    (o_irq)
  );

endmodule

// File: tb/tb_intel_fpga_pb_event_detect.sv
module tb_intel_fpga_pb_event_detect;

  localparam int LONG_T = 1000;
  localparam int REP_T  = 250;

  logic       clk = 1'b0;
  logic       rst, sample_en, i_pb;
  logic [3:0] i_irq_mask, i_clr;
  logic       o_press, o_release, o_long, o_repeat, o_held, o_irq;
  logic [3:0] o_status;

  always #5 clk = ~clk;

  intel_fpga_pb_event_detect #(
    .ACTIVE_LOW(1), .CNT_W(16), .LONG_TICKS(LONG_T), .REPEAT_TICKS(REP_T)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .i_pb(i_pb),
    .i_irq_mask(i_irq_mask), .i_clr(i_clr),
    .o_press(o_press), .o_release(o_release), .o_long(o_long),
    .o_repeat(o_repeat), .o_held(o_held), .o_status(o_status), .o_irq(o_irq)
  );

  int checks, failures;

  // Reference model: tracks how many consecutive pressed samples followed
  // the most recent press edge, and derives events from that hold length.
  bit         m_first, m_prev, m_held, m_irq;
  int         m_hold;
  logic [3:0] m_status;
  int         obs_cnt[4], exp_cnt[4], snap[4];
  int         mism;
  logic [9:0] bad_obs, bad_exp;

  task automatic model_reset();
    m_first = 1; m_prev = 0; m_held = 0; m_irq = 0; m_hold = 0; m_status = '0;
  endtask

  task automatic snapshot();
    for (int k = 0; k < 4; k++) snap[k] = obs_cnt[k];
  endtask

  // One clk: drive inputs, advance model at the edge, record any per-cycle
  // divergence and count high cycles of each pulse output.
  task automatic tick(input logic se, input logic pb, input logic [3:0] clr);
    logic       pr;
    logic [3:0] ev, pulses;
    logic [9:0] o, e;
    sample_en = se; i_pb = pb; i_clr = clr;
    @(posedge clk);
    ev = '0;
    if (se) begin
      pr = ~pb;
      if (m_first) begin
        m_first = 0; m_hold = 0;
      end else if (pr && !m_prev) begin
        ev[0] = 1; m_hold = 0;
      end else if (!pr && m_prev) begin
        ev[1] = 1;
      end else if (pr) begin
        m_hold++;
        if (m_hold == LONG_T) ev[2] = 1;
        else if (m_hold > LONG_T && (m_hold - LONG_T) % REP_T == 0) ev[3] = 1;
      end
      m_prev = pr; m_held = pr;
    end
    m_status = (m_status & ~clr) | ev;
    m_irq    = |(m_status & i_irq_mask);
    #1;
    pulses = {o_repeat, o_long, o_release, o_press};
    o = {pulses, o_held, o_status, o_irq};
    e = {ev, m_held, m_status, m_irq};
    if (o !== e) begin mism++; bad_obs = o; bad_exp = e; end
    for (int k = 0; k < 4; k++) begin
      obs_cnt[k] += int'(pulses[k]);
      exp_cnt[k] += int'(ev[k]);
    end
  endtask

  // n sample ticks at a fixed level, with random idle clks (random pb) between.
  task automatic samples(input int n, input logic pb);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom), 4'b0);
      tick(1'b1, pb, 4'b0);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({o_press, o_release, o_long, o_repeat, o_held} !== 5'b0) begin
      failures++; $display("FAIL reset_pulses got=%b want=00000", {o_press, o_release, o_long, o_repeat, o_held});
    end
    checks++;
    if (o_status !== 4'b0) begin failures++; $display("FAIL reset_status got=%b want=0000", o_status); end
    checks++;
    if (o_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", o_irq); end
    // Button held (active low) across reset release.
    i_pb = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    mism = 0; snapshot();
    samples(10, 1'b0);
    checks++;
    if (obs_cnt[0] - snap[0] !== 0) begin failures++; $display("FAIL held_boot_press got=%0d want=0", obs_cnt[0] - snap[0]); end
    checks++;
    if (o_held !== 1'b1) begin failures++; $display("FAIL held_boot_held got=%b want=1", o_held); end
    checks++;
    if (o_status !== 4'b0) begin failures++; $display("FAIL held_boot_status got=%b want=0000", o_status); end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL held_boot_model n=%0d got=%b want=%b", mism, bad_obs, bad_exp); end
  endtask

  task automatic test_press_release();
    mism = 0;
    samples(2, 1'b1);
    tick(1'b0, 1'b1, 4'hF);
    snapshot();
    samples(5, 1'b0);
    samples(1, 1'b1);
    checks++;
    if (obs_cnt[0] - snap[0] !== 1) begin failures++; $display("FAIL pr_press_cnt got=%0d want=1", obs_cnt[0] - snap[0]); end
    checks++;
    if (obs_cnt[1] - snap[1] !== 1) begin failures++; $display("FAIL pr_release_cnt got=%0d want=1", obs_cnt[1] - snap[1]); end
    checks++;
    if (o_status !== 4'b0011) begin failures++; $display("FAIL pr_status got=%b want=0011", o_status); end
    checks++;
    if (o_irq !== 1'b1) begin failures++; $display("FAIL pr_irq got=%b want=1", o_irq); end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL pr_model n=%0d got=%b want=%b", mism, bad_obs, bad_exp); end
  endtask

  task automatic test_long_repeat();
    mism = 0;
    tick(1'b0, 1'b1, 4'hF);
    snapshot();
    samples(1, 1'b0);
    samples(1500, 1'b0);
    checks++;
    if (obs_cnt[2] - snap[2] !== 1) begin failures++; $display("FAIL lr_long_cnt got=%0d want=1", obs_cnt[2] - snap[2]); end
    checks++;
    if (obs_cnt[3] - snap[3] !== 2) begin failures++; $display("FAIL lr_repeat_cnt got=%0d want=2", obs_cnt[3] - snap[3]); end
    checks++;
    if (o_status !== 4'b1101) begin failures++; $display("FAIL lr_status got=%b want=1101", o_status); end
    checks++;
    if (o_held !== 1'b1) begin failures++; $display("FAIL lr_held got=%b want=1", o_held); end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL lr_model n=%0d got=%b want=%b", mism, bad_obs, bad_exp); end
  endtask

  // Continues the hold from test_long_repeat, which ended on a repeat.
  task automatic test_release_on_repeat();
    mism = 0;
    snapshot();
    samples(REP_T - 1, 1'b0);
    samples(1, 1'b1);
    checks++;
    if (obs_cnt[3] - snap[3] !== 0) begin failures++; $display("FAIL rr_repeat_cnt got=%0d want=0", obs_cnt[3] - snap[3]); end
    checks++;
    if (obs_cnt[1] - snap[1] !== 1) begin failures++; $display("FAIL rr_release_cnt got=%0d want=1", obs_cnt[1] - snap[1]); end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL rr_model n=%0d got=%b want=%b", mism, bad_obs, bad_exp); end
  endtask

  task automatic test_clr_collision();
    mism = 0;
    tick(1'b0, 1'b1, 4'hF);
    samples(2, 1'b1);
    tick(1'b1, 1'b0, 4'b0001);
    checks++;
    if (o_press !== 1'b1) begin failures++; $display("FAIL cc_press got=%b want=1", o_press); end
    checks++;
    if (o_status[0] !== 1'b1) begin failures++; $display("FAIL cc_set_wins got=%b want=1", o_status[0]); end
    checks++;
    if (o_irq !== 1'b1) begin failures++; $display("FAIL cc_irq got=%b want=1", o_irq); end
    i_irq_mask = 4'h0;
    tick(1'b0, 1'b0, 4'b0);
    checks++;
    if (o_irq !== 1'b0) begin failures++; $display("FAIL cc_mask_irq got=%b want=0", o_irq); end
    tick(1'b0, 1'b0, 4'b0001);
    checks++;
    if (o_status[0] !== 1'b0) begin failures++; $display("FAIL cc_clear got=%b want=0", o_status[0]); end
    i_irq_mask = 4'hF;
    tick(1'b0, 1'b0, 4'b0);
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL cc_model n=%0d got=%b want=%b", mism, bad_obs, bad_exp); end
  endtask

  task automatic test_reset_mid_hold();
    mism = 0;
    samples(1, 1'b1);
    samples(1, 1'b0);
    samples(1300, 1'b0);
    rst = 1'b1; sample_en = 1'b0;
    #2;
    checks++;
    if ({o_press, o_release, o_long, o_repeat, o_held, o_status, o_irq} !== 10'b0) begin
      failures++; $display("FAIL mh_reset got=%b want=0000000000", {o_press, o_release, o_long, o_repeat, o_held, o_status, o_irq});
    end
    model_reset();
    @(posedge clk); #1; rst = 1'b0;
    snapshot();
    samples(20, 1'b0);
    checks++;
    if (obs_cnt[0] - snap[0] !== 0) begin failures++; $display("FAIL mh_no_press got=%0d want=0", obs_cnt[0] - snap[0]); end
    checks++;
    if (obs_cnt[2] - snap[2] !== 0) begin failures++; $display("FAIL mh_no_long got=%0d want=0", obs_cnt[2] - snap[2]); end
    checks++;
    if (o_held !== 1'b1) begin failures++; $display("FAIL mh_held got=%b want=1", o_held); end
    samples(1, 1'b1);
    samples(1, 1'b0);
    checks++;
    if (obs_cnt[0] - snap[0] !== 1) begin failures++; $display("FAIL mh_repress got=%0d want=1", obs_cnt[0] - snap[0]); end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL mh_model n=%0d got=%b want=%b", mism, bad_obs, bad_exp); end
  endtask

  // sample_en every clk with the level toggling every sample; starts held.
  task automatic test_back_to_back();
    mism = 0;
    tick(1'b0, 1'b0, 4'hF);
    snapshot();
    for (int i = 0; i < 40; i++) tick(1'b1, 1'(i % 2), 4'b0);
    checks++;
    if (obs_cnt[0] - snap[0] !== 19) begin failures++; $display("FAIL b2b_press got=%0d want=19", obs_cnt[0] - snap[0]); end
    checks++;
    if (obs_cnt[1] - snap[1] !== 20) begin failures++; $display("FAIL b2b_release got=%0d want=20", obs_cnt[1] - snap[1]); end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL b2b_model n=%0d got=%b want=%b", mism, bad_obs, bad_exp); end
  endtask

  task automatic test_random();
    logic pb;
    mism = 0;
    pb = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) i_irq_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) pb = ~pb;
      tick(($urandom_range(0, 2) == 0), pb, ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0);
    end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL rand_model n=%0d got=%b want=%b", mism, bad_obs, bad_exp); end
  endtask

  initial begin
    checks = 0; failures = 0; mism = 0;
    for (int k = 0; k < 4; k++) begin obs_cnt[k] = 0; exp_cnt[k] = 0; snap[k] = 0; end
    rst = 1'b1; sample_en = 1'b0; i_pb = 1'b1; i_clr = 4'b0; i_irq_mask = 4'hF;
    model_reset();
    test_reset();
    test_press_release();
    test_long_repeat();
    test_release_on_repeat();
    test_clr_collision();
    test_reset_mid_hold();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
